// File: rtl/board_pkg.sv
// Shared definitions for the battleship board: cell encodings, command opcodes and geometry.
// Used by board_cell_map and pix_to_cell.
package board_pkg;

    localparam int GRID_W    = 10;
    localparam int GRID_H    = 10;
    localparam int CELL_PX_W = 64;
    localparam int CELL_PX_H = 48;
    localparam int ACTIVE_W  = 640;
    localparam int ACTIVE_H  = 480;
    localparam int NUM_CELLS = GRID_W * GRID_H;

    typedef enum logic [1:0] {
        CELL_FREE     = 2'b00,
        CELL_OCC      = 2'b01,
        CELL_HIT      = 2'b10,
        CELL_OUTBOUND = 2'b11
    } cell_t;

    typedef enum logic [1:0] {
        OP_PLACE = 2'b00,
        OP_FIRE  = 2'b01,
        OP_CLEAR = 2'b10,
        OP_RSVD  = 2'b11
    } op_t;

    // Row-major linear index; only meaningful for in-range coordinates.
    function automatic logic [6:0] cell_index(input logic [3:0] x, input logic [3:0] y);
        return 7'(y) * 7'(GRID_W) + 7'(x);
    endfunction

endpackage

// File: rtl/pix_to_cell.sv
// Combinational pixel-to-cell mapper: column from the pixel column bits, row from a
// comparator ladder on the line number, plus an outbound flag for non-active pixels.
module pix_to_cell
    import board_pkg::*;
(
    input  logic [9:0] current_row,
    input  logic [9:0] current_line,
    input  logic       enable,
    output logic [3:0] cell_x,
    output logic [3:0] cell_y,
    output logic       outbound
);

    // Cells are 64 px wide, so the column is just the upper bits.
    assign cell_x = current_row[9:6];

    always_comb begin
        // NOTE: every variable written in always_comb gets a default first, otherwise a latch is inferred.
        cell_y = '0;
        for (int i = 1; i < GRID_H; i++) begin
            if (current_line >= 10'(i * CELL_PX_H)) begin
                cell_y = 4'(i);
            end
        end
    end

    assign outbound = !enable
                    || (current_row  >= 10'(ACTIVE_W))
                    || (current_line >= 10'(ACTIVE_H));

endmodule

// File: rtl/board_cell_map.sv
// Battleship board state store: 10x10 map of 2-bit cells with a command FSM and a
// 1-cycle registered pixel read port. Define BOARD_FOG_EN to report OCC cells as FREE.
module board_cell_map
    import board_pkg::*;
(
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic [9:0] current_row,
    input  logic [9:0] current_line,
    input  logic       enable,
    output logic [1:0] cell_status,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [3:0] cmd_x,
    input  logic [3:0] cmd_y,
    output logic       resp_valid,
    output logic       resp_hit,
    output logic       resp_err,
    output logic [6:0] ships_left,
    output logic       all_sunk
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_EXEC  = 2'd1;
    localparam logic [1:0] ST_CLEAR = 2'd2;

    logic [1:0] state;
    op_t        op_q;
    logic [3:0] x_q;
    logic [3:0] y_q;
    logic [6:0] clr_idx;
    logic       placed;

    cell_t      map [NUM_CELLS];

    // Read path
    logic [3:0] rd_x;
    logic [3:0] rd_y;
    logic       rd_outbound;
    cell_t      rd_cell;
    cell_t      rd_view;

    pix_to_cell u_pix_to_cell (
        .current_row  (current_row),
        .current_line (current_line),
        .enable       (enable),
        .cell_x       (rd_x),
        .cell_y       (rd_y),
        .outbound     (rd_outbound)
    );

    always_comb begin
        rd_cell = rd_outbound ? CELL_OUTBOUND : map[cell_index(rd_x, rd_y)];
`ifdef BOARD_FOG_EN
        rd_view = (rd_cell == CELL_OCC) ? CELL_FREE : rd_cell;
`else
        rd_view = rd_cell;
`endif
    end

    always_ff @(posedge clk_in) begin
        // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
        if (rst_in) begin
            cell_status <= CELL_OUTBOUND;
        end else begin
            cell_status <= rd_view;
        end
    end

    // Command evaluation for the latched command
    logic       in_range;
    logic [6:0] exec_idx;
    cell_t      exec_cur;
    logic       wr_en;
    logic [6:0] wr_idx;
    cell_t      wr_data;
    logic       ex_hit;
    logic       ex_err;
    logic       ships_inc;
    logic       ships_dec;

    assign in_range = (x_q < 4'(GRID_W)) && (y_q < 4'(GRID_H));
    assign exec_idx = cell_index(x_q, y_q);
    assign exec_cur = in_range ? map[exec_idx] : CELL_OUTBOUND;

    always_comb begin
        wr_en     = 1'b0;
        wr_idx    = exec_idx;
        wr_data   = CELL_FREE;
        ex_hit    = 1'b0;
        ex_err    = 1'b0;
        ships_inc = 1'b0;
        ships_dec = 1'b0;
        if (state == ST_EXEC) begin
            if (op_q == OP_PLACE && in_range) begin
                if (exec_cur == CELL_FREE) begin
                    wr_en     = 1'b1;
                    wr_data   = CELL_OCC;
                    ships_inc = 1'b1;
                end else begin
                    ex_err = 1'b1;
                end
            end else if (op_q == OP_FIRE && in_range) begin
                if (exec_cur == CELL_OCC) begin
                    wr_en     = 1'b1;
                    wr_data   = CELL_HIT;
                    ex_hit    = 1'b1;
                    ships_dec = 1'b1;
                end else if (exec_cur != CELL_FREE) begin
                    ex_err = 1'b1;
                end
            end else begin
                // Out-of-range target or reserved opcode.
                ex_err = 1'b1;
            end
        end else if (state == ST_CLEAR) begin
            wr_en   = 1'b1;
            wr_idx  = clr_idx;
            wr_data = CELL_FREE;
        end
    end

    // Single write port into the map
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            // NOTE: the map is reset explicitly because every cell must read FREE right after reset.
            for (int i = 0; i < NUM_CELLS; i++) begin
                map[i] <= CELL_FREE;
            end
        end else if (wr_en) begin
            map[wr_idx] <= wr_data;
        end
    end

    // Control FSM, counter and response
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state      <= ST_IDLE;
            op_q       <= OP_PLACE;
            x_q        <= '0;
            y_q        <= '0;
            clr_idx    <= '0;
            placed     <= 1'b0;
            ships_left <= '0;
            resp_valid <= 1'b0;
            resp_hit   <= 1'b0;
            resp_err   <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            resp_hit   <= 1'b0;
            resp_err   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        op_q    <= op_t'(cmd_op);
                        x_q     <= cmd_x;
                        y_q     <= cmd_y;
                        clr_idx <= '0;
                        state   <= (cmd_op == OP_CLEAR) ? ST_CLEAR : ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    resp_valid <= 1'b1;
                    resp_hit   <= ex_hit;
                    resp_err   <= ex_err;
                    if (ships_inc) begin
                        placed <= 1'b1;
                        if (ships_left < 7'(NUM_CELLS)) begin
                            ships_left <= ships_left + 7'd1;
                        end
                    end
                    if (ships_dec && ships_left != 7'd0) begin
                        ships_left <= ships_left - 7'd1;
                    end
                    state <= ST_IDLE;
                end
                ST_CLEAR: begin
                    if (clr_idx == 7'(NUM_CELLS - 1)) begin
                        ships_left <= '0;
                        placed     <= 1'b0;
                        resp_valid <= 1'b1;
                        state      <= ST_IDLE;
                    end else begin
                        clr_idx <= clr_idx + 7'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready = (state == ST_IDLE);
    assign all_sunk  = placed && (ships_left == 7'd0);

endmodule

// File: tb/tb_board_cell_map.sv
// Self-checking bench for board_cell_map: scoreboard of command responses from a
// behavioural board model, plus direct pixel read checks. Honours BOARD_FOG_EN.
module tb_board_cell_map;
    import board_pkg::*;

    logic       clk_in = 1'b0;
    logic       rst_in;
    logic [9:0] current_row;
    logic [9:0] current_line;
    logic       enable;
    logic [1:0] cell_status;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_x;
    logic [3:0] cmd_y;
    logic       resp_valid;
    logic       resp_hit;
    logic       resp_err;
    logic [6:0] ships_left;
    logic       all_sunk;

    always #5 clk_in = ~clk_in;

    board_cell_map dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .current_row  (current_row),
        .current_line (current_line),
        .enable       (enable),
        .cell_status  (cell_status),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_x        (cmd_x),
        .cmd_y        (cmd_y),
        .resp_valid   (resp_valid),
        .resp_hit     (resp_hit),
        .resp_err     (resp_err),
        .ships_left   (ships_left),
        .all_sunk     (all_sunk)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Behavioural board model
    logic [1:0] m_map [100];
    int         m_ships;
    bit         m_placed;

    typedef struct {
        bit hit;
        bit err;
        int ships;
        bit sunk;
    } exp_t;

    exp_t exp_q[$];

    function automatic void model_reset();
        for (int i = 0; i < 100; i++) m_map[i] = 2'b00;
        m_ships  = 0;
        m_placed = 0;
    endfunction

    function automatic exp_t model_cmd(input int op, input int x, input int y);
        exp_t r;
        int   idx;
        r.hit = 0;
        r.err = 0;
        if (op == 2) begin
            for (int i = 0; i < 100; i++) m_map[i] = 2'b00;
            m_ships  = 0;
            m_placed = 0;
        end else if (op == 3 || x >= 10 || y >= 10) begin
            r.err = 1;
        end else begin
            idx = y * 10 + x;
            if (op == 0) begin
                if (m_map[idx] == 2'b00) begin
                    m_map[idx] = 2'b01;
                    if (m_ships < 100) m_ships++;
                    m_placed = 1;
                end else begin
                    r.err = 1;
                end
            end else begin
                if (m_map[idx] == 2'b01) begin
                    m_map[idx] = 2'b10;
                    r.hit = 1;
                    if (m_ships > 0) m_ships--;
                end else if (m_map[idx] != 2'b00) begin
                    r.err = 1;
                end
            end
        end
        r.ships = m_ships;
        r.sunk  = m_placed && (m_ships == 0);
        return r;
    endfunction

    function automatic logic [1:0] exp_pix(input int row, input int line, input bit en);
        logic [1:0] v;
        if (!en || row >= 640 || line >= 480) return 2'b11;
        v = m_map[(line / 48) * 10 + (row / 64)];
`ifdef BOARD_FOG_EN
        if (v == 2'b01) v = 2'b00;
`endif
        return v;
    endfunction

    // Drive a pixel on a falling edge and compare the registered status one cycle later.
    task automatic check_pix(input string tag, input int row, input int line, input bit en);
        current_row  = 10'(row);
        current_line = 10'(line);
        enable       = en;
        @(negedge clk_in);
        check(tag, 32'(cell_status), 32'(exp_pix(row, line, en)));
    endtask

    // Present one command, wait (bounded) for acceptance, push the expected response.
    task automatic issue(input string tag, input int op, input int x, input int y);
        int n = 0;
        while (!cmd_ready && n < 300) begin
            @(negedge clk_in);
            n++;
        end
        if (!cmd_ready) check({tag, "_ready_timeout"}, 0, 1);
        cmd_op    = 2'(op);
        cmd_x     = 4'(x);
        cmd_y     = 4'(y);
        cmd_valid = 1'b1;
        exp_q.push_back(model_cmd(op, x, y));
        @(negedge clk_in);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_resp(input string tag, input int limit);
        int   n = 0;
        exp_t e;
        while (!resp_valid && n < limit) begin
            @(negedge clk_in);
            n++;
        end
        if (!resp_valid) begin
            check({tag, "_resp_timeout"}, 0, 1);
        end else if (exp_q.size() == 0) begin
            check({tag, "_unexpected_resp"}, 1, 0);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_hit"},   32'(resp_hit),   32'(e.hit));
            check({tag, "_err"},   32'(resp_err),   32'(e.err));
            check({tag, "_ships"}, 32'(ships_left), 32'(e.ships));
            check({tag, "_sunk"},  32'(all_sunk),   32'(e.sunk));
        end
    endtask

    task automatic do_cmd(input string tag, input int op, input int x, input int y);
        issue(tag, op, x, y);
        wait_resp(tag, 300);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int low_cnt;
        int pulses;

        rst_in       = 1'b1;
        cmd_valid    = 1'b0;
        cmd_op       = 2'b00;
        cmd_x        = '0;
        cmd_y        = '0;
        current_row  = 10'd100;
        current_line = 10'd100;
        enable       = 1'b1;
        model_reset();
        repeat (3) @(negedge clk_in);

        check("rst_status", 32'(cell_status), 32'(3));
        check("rst_ready",  32'(cmd_ready),   1);
        check("rst_rvalid", 32'(resp_valid),  0);
        check("rst_hit",    32'(resp_hit),    0);
        check("rst_err",    32'(resp_err),    0);
        check("rst_ships",  32'(ships_left),  0);
        check("rst_sunk",   32'(all_sunk),    0);
        rst_in = 1'b0;

        // Read path after reset
        check_pix("rd_free",    100, 100, 1);
        check_pix("rd_row640",  640, 100, 1);
        check_pix("rd_line480", 100, 480, 1);
        check_pix("rd_en0",     100, 100, 0);
        check_pix("rd_corner",  639, 479, 1);

        // Place and fire sequence on (3,2)
        do_cmd("place_3_2", 0, 3, 2);
        check_pix("rd_occ_3_2", 200, 100, 1);
        do_cmd("fire_3_2", 1, 3, 2);
        do_cmd("refire_3_2", 1, 3, 2);
        do_cmd("fire_miss_0_0", 1, 0, 0);
        check_pix("rd_hit_3_2", 200, 100, 1);

        // Rejected commands
        do_cmd("place_oob_x", 0, 10, 4);
        do_cmd("op_rsvd", 3, 1, 1);
        do_cmd("place_5_5", 0, 5, 5);
        do_cmd("place_occ_5_5", 0, 5, 5);
        do_cmd("fire_oob_y", 1, 4, 15);
        check_pix("rd_5_5", 5 * 64 + 1, 5 * 48 + 1, 1);

        // Ladder boundaries and the last cell
        do_cmd("place_9_9", 0, 9, 9);
        do_cmd("place_0_1", 0, 0, 1);
        check_pix("rd_9_9",     639, 479, 1);
        check_pix("rd_line47",  0, 47, 1);
        check_pix("rd_line48",  0, 48, 1);
        check_pix("rd_line431", 600, 431, 1);
        check_pix("rd_line432", 600, 432, 1);

        // Clear: 100 busy cycles then one response
        do_cmd("place_7_3", 0, 7, 3);
        do_cmd("place_2_8", 0, 2, 8);
        issue("clear", 2, 0, 0);
        low_cnt = 0;
        while (!resp_valid && low_cnt < 300) begin
            if (!cmd_ready) low_cnt++;
            @(negedge clk_in);
        end
        check("clear_busy_cycles", 32'(low_cnt), 32'(100));
        wait_resp("clear", 5);
        for (int y = 0; y < 10; y++) begin
            for (int x = 0; x < 10; x++) begin
                check_pix($sformatf("clr_%0d_%0d", x, y), x * 64 + 10, y * 48 + 10, 1);
            end
        end

        // Reset in the middle of a clear
        do_cmd("place_1_1", 0, 1, 1);
        do_cmd("place_2_2", 0, 2, 2);
        issue("clear_abort", 2, 0, 0);
        repeat (39) @(negedge clk_in);
        check("mid_clear_busy", 32'(cmd_ready), 0);
        rst_in = 1'b1;
        @(negedge clk_in);
        check("abort_ready",  32'(cmd_ready),  1);
        check("abort_rvalid", 32'(resp_valid), 0);
        check("abort_ships",  32'(ships_left), 0);
        rst_in = 1'b0;
        model_reset();
        exp_q.delete();
        pulses = 0;
        for (int i = 0; i < 110; i++) begin
            @(negedge clk_in);
            if (resp_valid) pulses++;
        end
        check("abort_no_resp", 32'(pulses), 0);
        check_pix("abort_rd_1_1", 64 + 5, 48 + 5, 1);
        check_pix("abort_rd_2_2", 128 + 5, 96 + 5, 1);
        do_cmd("after_abort_place", 0, 4, 4);
        check_pix("after_abort_rd", 4 * 64 + 5, 4 * 48 + 5, 1);

        check("queue_empty", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
